cam_pattern_tx: RTL
===================

// Module: cam_pattern_tx
// PURPOSE
//   Camera-sensor emulator: generates OV-style parallel video (VSYNC, HREF, D[7:0]) clocked by PCLKI.
//   Drives the FPGA camera capture path, which packs bytes while HREF & VSYNC are high, for loopback/bring-up.
//   Emits programmable test patterns with deterministic frame/line timing.
//   Counts completed frames for host readback through the Wishbone register block.
// PARAMETERS
//   H_ACTIVE  8  bytes per line (HREF high cycles), >=1; multiple of 4 for whole capture words
//   H_BLANK   4  HREF-low cycles after every line, >=1
//   V_LINES   2  active lines per frame, >=1
//   V_SETUP   3  cycles VSYNC high before first HREF, >=1
//   V_HOLD    2  cycles VSYNC high after last line blank, >=1
//   V_BLANK   5  cycles VSYNC low before each frame, >=1
// PORTS
//   PCLKI         in   1   pixel clock; all logic on rising edge
//   WBs_RST_i     in   1   reset, asynchronous, active-high
//   en_i          in   1   level: run frames continuously while high
//   mode_i        in   2   pattern: 0 incrementing, 1 constant, 2 line/col, 3 = same as 0
//   seed_i        in   8   start value (mode 0) / constant value (mode 1)
//   VSYNC_O       out  1   frame valid, active-high
//   HREF_O        out  1   line valid, active-high
//   DATA_O        out  8   pixel byte
//   busy_o        out  1   high when state != IDLE
//   frame_done_o  out  1   1-cycle pulse at end of each frame
//   frame_cnt_o   out  16  completed-frame count
// BEHAVIOUR
//   Reset clears all outputs and counters to 0; state = IDLE. Takes effect immediately.
//   Reset mid-frame drops VSYNC_O and HREF_O at once; the partial frame is not counted.
//   All outputs are registered and change only on the rising edge of PCLKI.
//   FSM: IDLE -> VBLANK -> VSETUP -> ACTIVE <-> HBLANK -> VHOLD -> (VBLANK | IDLE).
//     IDLE:   VSYNC=0, HREF=0, DATA=0. If en_i=1 at an edge, latch mode_i/seed_i and go to VBLANK.
//     VBLANK: VSYNC=0 for V_BLANK cycles.
//     VSETUP: VSYNC=1, HREF=0 for V_SETUP cycles.
//     ACTIVE: VSYNC=1, HREF=1 for H_ACTIVE cycles; one byte per cycle.
//     HBLANK: HREF=0 for H_BLANK cycles. Then ACTIVE if lines < V_LINES, else VHOLD.
//     VHOLD:  VSYNC=1, HREF=0 for V_HOLD cycles.
//   End of VHOLD: go to VBLANK if en_i=1, else IDLE.
//   en_i dropping mid-frame never truncates a frame; generation stops only at the frame boundary.
//   Frame period = V_BLANK + V_SETUP + V_LINES*(H_ACTIVE+H_BLANK) + V_HOLD (34 cycles at defaults).
//   mode_i and seed_i are latched only when entering VBLANK; changes mid-frame are ignored.
//   DATA_O = 8'h00 whenever HREF_O=0.
//   Mode 0: first byte of frame = seed; +1 per active byte; 8'hFF wraps to 8'h00; continues across lines.
//   Mode 1: every active byte = seed.
//   Mode 2: byte = {line[3:0], col[3:0]}; line and col start at 0 and wrap mod 16.
//   frame_done_o pulses on the last VHOLD cycle.
//   frame_cnt_o increments on the edge that leaves VHOLD; 16'hFFFF wraps to 16'h0000.
//   Internal counters are sized to hold each parameter value (>=16 bits).
// TESTING
//   - Reset, en_i=0 for 20 cycles -> VSYNC/HREF/DATA/busy/frame_cnt all 0.
//   - en_i=1, mode 0, seed 8'hFE, defaults -> line0 bytes FE,FF,00..05; line1 06..0D; frame_done at cycle 34; frame_cnt=1.
//   - Mode 2, V_LINES=2 -> line0 bytes 00..07, line1 bytes 10..17; HREF high for exactly 8 cycles per line.
//   - en_i=1 for 1 cycle only -> exactly one full 34-cycle frame, then IDLE; busy_o low after it.
//   - mode_i 1->0 mid-frame -> current frame stays constant seed; next frame incrementing.
//   - Assert WBs_RST_i during ACTIVE -> VSYNC and HREF low same cycle; frame_cnt unchanged (0).
//   - Preload frame_cnt to 16'hFFFF via forced run -> next frame_cnt = 0.

Source files
------------

// File: rtl/cam_pattern_tx_if.sv
// Camera-side parallel video bundle for cam_pattern_tx.
// master: the pattern generator (drives video and status, takes run controls).
// slave:  the capture/host side (drives run controls, observes video and status).
interface cam_pattern_tx_if;
  logic        en_i;
  logic [1:0]  mode_i;
  logic [7:0]  seed_i;
  logic        VSYNC_O;
  logic        HREF_O;
  logic [7:0]  DATA_O;
  logic        busy_o;
  logic        frame_done_o;
  logic [15:0] frame_cnt_o;

  modport master (
    input  en_i, mode_i, seed_i,
    output VSYNC_O, HREF_O, DATA_O, busy_o, frame_done_o, frame_cnt_o
  );

  modport slave (
    output en_i, mode_i, seed_i,
    input  VSYNC_O, HREF_O, DATA_O, busy_o, frame_done_o, frame_cnt_o
  );
endinterface

// File: rtl/cam_pattern_tx.sv
// Camera-sensor emulator: OV-style VSYNC/HREF/DATA test-pattern source.
// Frames repeat while en_i is high; a frame that has started always completes.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | outputs low; waiting for en_i (mode/seed latched on exit)
//   VBLANK | VSYNC low, V_BLANK cycles before each frame
//   VSETUP | VSYNC high, HREF low, V_SETUP cycles before the first line
//   ACTIVE | VSYNC+HREF high, one pattern byte per cycle, H_ACTIVE cycles
//   HBLANK | HREF low, H_BLANK cycles after every line
//   VHOLD  | VSYNC high, HREF low, V_HOLD cycles; frame_done on last one
//
// Every output is a flop loaded from the next-state decode, so all outputs
// line up with the state register and change only on PCLKI.
module cam_pattern_tx #(
  parameter int H_ACTIVE = 8,
  parameter int H_BLANK  = 4,
  parameter int V_LINES  = 2,
  parameter int V_SETUP  = 3,
  parameter int V_HOLD   = 2,
  parameter int V_BLANK  = 5
) (
  input  logic             PCLKI,
  input  logic             WBs_RST_i,
  cam_pattern_tx_if.master cam
);

  localparam int MAX_A = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
  localparam int MAX_B = (V_LINES  > V_SETUP) ? V_LINES  : V_SETUP;
  localparam int MAX_C = (V_HOLD   > V_BLANK) ? V_HOLD   : V_BLANK;
  localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_P  = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CW     = ($clog2(MAX_P + 1) > 16) ? $clog2(MAX_P + 1) : 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VBLANK = 3'd1;
  localparam logic [2:0] S_VSETUP = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  localparam logic [2:0] S_VHOLD  = 3'd5;

  // Timer reload values: a state lasting N cycles loads N-1 and exits at 0.
  localparam logic [CW-1:0] LD_VBLANK = CW'(V_BLANK - 1);
  localparam logic [CW-1:0] LD_VSETUP = CW'(V_SETUP - 1);
  localparam logic [CW-1:0] LD_ACTIVE = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] LD_HBLANK = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] LD_VHOLD  = CW'(V_HOLD - 1);
  localparam logic [CW-1:0] N_LINES   = CW'(V_LINES);

  logic [2:0]    state_q, state_nxt;
  logic [CW-1:0] tmr_q, tmr_nxt;
  logic [CW-1:0] line_q;
  logic [3:0]    col_q;
  logic [1:0]    mode_q;
  logic [7:0]    seed_q;
  logic [7:0]    inc_q;
  logic [7:0]    byte_nxt;
  logic          frame_start;

  logic          vsync_q;
  logic          href_q;
  logic [7:0]    data_q;
  logic          busy_q;
  logic          done_q;
  logic [15:0]   frame_cnt_q;

  // Next-state and down-counter reload decode.
  always_comb begin
    state_nxt = state_q;
    tmr_nxt   = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (cam.en_i) begin
          state_nxt = S_VBLANK;
          tmr_nxt   = LD_VBLANK;
        end
      end
      S_VBLANK: begin
        if (tmr_q == '0) begin
          state_nxt = S_VSETUP;
          tmr_nxt   = LD_VSETUP;
        end else begin
          tmr_nxt = tmr_q - CW'(1);
        end
      end
      S_VSETUP: begin
        if (tmr_q == '0) begin
          state_nxt = S_ACTIVE;
          tmr_nxt   = LD_ACTIVE;
        end else begin
          tmr_nxt = tmr_q - CW'(1);
        end
      end
      S_ACTIVE: begin
        if (tmr_q == '0) begin
          state_nxt = S_HBLANK;
          tmr_nxt   = LD_HBLANK;
        end else begin
          tmr_nxt = tmr_q - CW'(1);
        end
      end
      S_HBLANK: begin
        // line_q already counts the line that just finished.
        if (tmr_q == '0) begin
          if (line_q < N_LINES) begin
            state_nxt = S_ACTIVE;
            tmr_nxt   = LD_ACTIVE;
          end else begin
            state_nxt = S_VHOLD;
            tmr_nxt   = LD_VHOLD;
          end
        end else begin
          tmr_nxt = tmr_q - CW'(1);
        end
      end
      S_VHOLD: begin
        if (tmr_q == '0) begin
          if (cam.en_i) begin
            state_nxt = S_VBLANK;
            tmr_nxt   = LD_VBLANK;
          end else begin
            state_nxt = S_IDLE;
            tmr_nxt   = '0;
          end
        end else begin
          tmr_nxt = tmr_q - CW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        tmr_nxt   = '0;
      end
    endcase
  end

  assign frame_start = (state_nxt == S_VBLANK) && (state_q != S_VBLANK);

  // Pattern byte for the cycle about to be presented (used only when ACTIVE is next).
  always_comb begin
    byte_nxt = inc_q;
    case (mode_q)
      2'd1:    byte_nxt = seed_q;
      2'd2:    byte_nxt = {line_q[3:0], col_q};
      default: byte_nxt = inc_q;
    endcase
  end

  // State register and phase timer.
  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_nxt;
      tmr_q   <= tmr_nxt;
    end
  end

  // Pattern configuration is frozen for the whole frame from its VBLANK entry.
  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      mode_q <= 2'd0;
      seed_q <= 8'h00;
    end else if (frame_start) begin
      mode_q <= cam.mode_i;
      seed_q <= cam.seed_i;
    end
  end

  // Pixel position and running byte value; restart at every frame.
  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      inc_q  <= 8'h00;
      line_q <= '0;
      col_q  <= 4'd0;
    end else if (frame_start) begin
      inc_q  <= cam.seed_i;
      line_q <= '0;
      col_q  <= 4'd0;
    end else if (state_nxt == S_ACTIVE) begin
      inc_q <= inc_q + 8'd1;
      col_q <= col_q + 4'd1;
    end else if (state_q == S_ACTIVE) begin
      col_q  <= 4'd0;
      line_q <= line_q + CW'(1);
    end
  end

  // Registered video and status outputs decoded from the next state.
  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      vsync_q <= (state_nxt == S_VSETUP) || (state_nxt == S_ACTIVE) ||
                 (state_nxt == S_HBLANK) || (state_nxt == S_VHOLD);
      href_q  <= (state_nxt == S_ACTIVE);
      data_q  <= (state_nxt == S_ACTIVE) ? byte_nxt : 8'h00;
      busy_q  <= (state_nxt != S_IDLE);
      done_q  <= (state_nxt == S_VHOLD) && (tmr_nxt == '0);
    end
  end

  // Completed-frame counter; bumps on the edge that leaves VHOLD, wraps naturally.
  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      frame_cnt_q <= 16'h0000;
    end else if ((state_q == S_VHOLD) && (tmr_q == '0)) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign cam.VSYNC_O      = vsync_q;
  assign cam.HREF_O       = href_q;
  assign cam.DATA_O       = data_q;
  assign cam.busy_o       = busy_q;
  assign cam.frame_done_o = done_q;
  assign cam.frame_cnt_o  = frame_cnt_q;

endmodule
